// File: rtl/pn_seq_checker.sv
// pn_seq_checker: receive-side checker for a 4-stage PN stream with the
// recurrence b[n+4] = b[n] ^ b[n+3] (period 15).
//
// A local predictor self-synchronises on the incoming bits in three steps:
// SEARCH fills the history, VERIFY confirms predictions, and LOCKED lets the
// predictor free-run (flywheel). While locked, the checker counts bit errors
// and detects loss of sync within fixed windows of valid bits.
//
// Optional feature: define PN_CHECK_BITCNT_EN to add the bit_cnt output. It
// counts the valid bits checked while LOCKED, so BER = err_cnt / bit_cnt.
//
// Input handshake: din is consumed on a rising edge only when din_valid is 1.
// There is no backpressure. Cycles with din_valid=0 leave all state unchanged
// and clear the one-cycle pulses.
module pn_seq_checker #(
    parameter int LOCK_CNT = 8,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             din,
    input  logic             din_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             loss_pulse,
`ifdef PN_CHECK_BITCNT_EN
    output logic [CNT_W-1:0] bit_cnt,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WC_W    = $clog2(WIN_LEN + 1);
    localparam int WE_W    = $clog2(LOSS_THR + 1);

    localparam logic [MATCH_W-1:0] LOCK_CNT_C = MATCH_W'(LOCK_CNT);
    localparam logic [WC_W-1:0]    WIN_LEN_C  = WC_W'(WIN_LEN);
    localparam logic [WE_W-1:0]    LOSS_THR_C = WE_W'(LOSS_THR);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         hist_q, hist_d;       // hist[0] newest, hist[3] oldest
    logic [2:0]         fill_q, fill_d;       // bits collected in SEARCH, saturates at 4
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WC_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WE_W-1:0]    win_err_q, win_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               loss_pulse_q, loss_pulse_d;
`ifdef PN_CHECK_BITCNT_EN
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
`endif

    logic pred;

    // The next PN bit predicted from the current history.
    assign pred = hist_q[3] ^ hist_q[0];

    // Compute the next state, history, counters and registered outputs for the consumed bit.
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        match_d      = match_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        err_cnt_d    = err_cnt_q;
        err_pulse_d  = 1'b0;
        loss_pulse_d = 1'b0;
`ifdef PN_CHECK_BITCNT_EN
        bit_cnt_d    = bit_cnt_q;
`endif
        if (din_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    hist_d = {hist_q[2:0], din};
                    if (fill_q != 3'd4) begin
                        fill_d = fill_q + 3'd1;
                    end
                    // All-zero history is the generator lock-up state, so it is never trusted.
                    if ((fill_d == 3'd4) && (hist_d != 4'b0000)) begin
                        state_d = ST_VERIFY;
                        match_d = '0;
                    end
                end
                ST_VERIFY: begin
                    hist_d = {hist_q[2:0], din};
                    if (din == pred) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == LOCK_CNT_C) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        // The history stays full, so the next bit re-enters VERIFY at once.
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction so channel errors cannot corrupt the predictor.
                    hist_d    = {hist_q[2:0], pred};
                    win_cnt_d = win_cnt_q + WC_W'(1);
`ifdef PN_CHECK_BITCNT_EN
                    if (bit_cnt_q != {CNT_W{1'b1}}) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
`endif
                    if (din != pred) begin
                        err_pulse_d = 1'b1;
                        win_err_d   = win_err_q + WE_W'(1);
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                    // The loss check runs before the window restart, so an error on the last bit still counts.
                    if (win_err_d == LOSS_THR_C) begin
                        state_d      = ST_SEARCH;
                        loss_pulse_d = 1'b1;
                        fill_d       = 3'd0;
                    end else if (win_cnt_d == WIN_LEN_C) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Register all state and outputs. Reset aborts immediately and clears every counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_SEARCH;
            hist_q       <= 4'b0000;
            fill_q       <= 3'd0;
            match_q      <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            err_cnt_q    <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            loss_pulse_q <= 1'b0;
`ifdef PN_CHECK_BITCNT_EN
            bit_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            match_q      <= match_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            err_cnt_q    <= err_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            loss_pulse_q <= loss_pulse_d;
`ifdef PN_CHECK_BITCNT_EN
            bit_cnt_q    <= bit_cnt_d;
`endif
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign loss_pulse = loss_pulse_q;
    assign err_cnt    = err_cnt_q;
`ifdef PN_CHECK_BITCNT_EN
    assign bit_cnt    = bit_cnt_q;
`endif

endmodule

// File: tb/tb_pn_seq_checker.sv
// tb_pn_seq_checker: directed and random stimulus for pn_seq_checker.
// A behavioural reference model predicts each cycle's outputs into exp_q.
// Directed end-of-test checks use constant expectations.
// Define PN_CHECK_BITCNT_EN here and in the DUT to cover bit_cnt.
module tb_pn_seq_checker;

    localparam int LOCK_CNT = 8;
    localparam int WIN_LEN  = 64;
    localparam int LOSS_THR = 8;
    localparam int CNT_W    = 16;
`ifdef PN_CHECK_BITCNT_EN
    localparam int OW = 3 + 2 * CNT_W;
`else
    localparam int OW = 3 + CNT_W;
`endif

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic din       = 1'b0;
    logic din_valid = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic             loss_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef PN_CHECK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    pn_seq_checker #(
        .LOCK_CNT (LOCK_CNT),
        .WIN_LEN  (WIN_LEN),
        .LOSS_THR (LOSS_THR),
        .CNT_W    (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .loss_pulse (loss_pulse),
`ifdef PN_CHECK_BITCNT_EN
        .bit_cnt    (bit_cnt),
`endif
        .err_cnt    (err_cnt)
    );

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [OW-1:0] exp_q[$];

    // PN reference sequence, seed 0110
    logic pn[15];
    int   pn_pos = 0;

    // per-test observation trackers
    int vcnt, lock_at, ep_seen, lp_seen;
    bit ever_locked, unlock_seen;

    // ---------------- reference model ----------------
    int         m_state;   // 0 search, 1 verify, 2 locked
    int         m_fill, m_match, m_wc, m_we, m_ec, m_bits;
    logic [3:0] mh;
    logic       m_ep, m_lp;
    localparam int SAT = (1 << CNT_W) - 1;

    function automatic void model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
        m_ec = 0; m_bits = 0; mh = 4'b0000; m_ep = 1'b0; m_lp = 1'b0;
    endfunction

    function automatic void model_step(input logic d, input logic v);
        logic p;
        m_ep = 1'b0;
        m_lp = 1'b0;
        if (v) begin
            p = mh[3] ^ mh[0];
            case (m_state)
                0: begin
                    mh = {mh[2:0], d};
                    if (m_fill < 4) m_fill++;
                    if (m_fill == 4 && mh != 4'b0000) begin
                        m_state = 1;
                        m_match = 0;
                    end
                end
                1: begin
                    mh = {mh[2:0], d};
                    if (d == p) begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_state = 2; m_wc = 0; m_we = 0;
                        end
                    end else begin
                        m_state = 0;
                    end
                end
                default: begin
                    mh = {mh[2:0], p};
                    m_wc++;
                    if (m_bits < SAT) m_bits++;
                    if (d != p) begin
                        m_ep = 1'b1;
                        m_we++;
                        if (m_ec < SAT) m_ec++;
                    end
                    if (m_we == LOSS_THR) begin
                        m_state = 0; m_lp = 1'b1; m_fill = 0;
                    end else if (m_wc == WIN_LEN) begin
                        m_wc = 0; m_we = 0;
                    end
                end
            endcase
        end
    endfunction

    function automatic logic [OW-1:0] model_vec();
        logic [CNT_W-1:0] ec;
        ec = CNT_W'(m_ec);
`ifdef PN_CHECK_BITCNT_EN
        return {m_state == 2, m_ep, m_lp, ec, CNT_W'(m_bits)};
`else
        return {m_state == 2, m_ep, m_lp, ec};
`endif
    endfunction

    function automatic logic [OW-1:0] get_obs();
`ifdef PN_CHECK_BITCNT_EN
        return {locked, err_pulse, loss_pulse, err_cnt, bit_cnt};
`else
        return {locked, err_pulse, loss_pulse, err_cnt};
`endif
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic next_pn();
        logic b;
        b = pn[pn_pos];
        pn_pos = (pn_pos + 1) % 15;
        return b;
    endfunction

    task automatic mark();
        vcnt = 0; lock_at = -1; ep_seen = 0; lp_seen = 0;
        ever_locked = 1'b0; unlock_seen = 1'b0;
    endtask

    task automatic step(input logic d, input logic v);
        logic [OW-1:0] e;
        @(negedge sys_clk);
        din       = d;
        din_valid = v;
        model_step(d, v);
        exp_q.push_back(model_vec());
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        chk("cycle_outputs", 64'(get_obs()), 64'(e));
        if (v) vcnt++;
        if (locked) begin
            if (lock_at < 0) lock_at = vcnt;
            ever_locked = 1'b1;
        end else begin
            unlock_seen = 1'b1;
        end
        if (err_pulse) ep_seen++;
        if (loss_pulse) lp_seen++;
    endtask

    task automatic clean(input int n);
        repeat (n) step(next_pn(), 1'b1);
    endtask

    task automatic flip();
        step(~next_pn(), 1'b1);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge sys_clk);
        din_valid = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_outputs", 64'(get_obs()), 64'(model_vec()));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        pn[0] = 1'b0; pn[1] = 1'b1; pn[2] = 1'b1; pn[3] = 1'b0;
        for (int n = 0; n < 11; n++) pn[n + 4] = pn[n] ^ pn[n + 3];
        model_reset();
        mark();

        #3;
        chk("reset_state", 64'(get_obs()), 64'(0));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 1: clean stream from reset
        pn_pos = 0;
        mark();
        clean(200);
        chk("t1_lock_bit", 64'(lock_at), 64'(12));
        chk("t1_err_cnt", 64'(err_cnt), 64'(0));
        chk("t1_pulses", 64'(ep_seen + lp_seen), 64'(0));
`ifdef PN_CHECK_BITCNT_EN
        chk("t1_bit_cnt", 64'(bit_cnt), 64'(188));
`endif

        // 2: single flipped bit while locked
        mark();
        flip();
        chk("t2_err_pulse", 64'(ep_seen), 64'(1));
        clean(30);
        chk("t2_no_propagation", 64'(ep_seen), 64'(1));
        chk("t2_err_cnt", 64'(err_cnt), 64'(1));
        chk("t2_stays_locked", 64'(unlock_seen), 64'(0));

        // 3: eight errors in one window force loss, then relock
        do_reset();
        clean(20);
        mark();
        for (int i = 0; i < 7; i++) begin
            flip();
            clean(1);
        end
        chk("t3_no_loss_at_7", 64'(lp_seen), 64'(0));
        flip();
        chk("t3_loss_pulse", 64'(lp_seen), 64'(1));
        chk("t3_unlocked", 64'(locked), 64'(0));
        mark();
        clean(12);
        chk("t3_relock_bit", 64'(lock_at), 64'(12));
        chk("t3_err_cnt", 64'(err_cnt), 64'(8));

        // window restart: 7 + 7 errors split across a window boundary never lose lock
        do_reset();
        clean(20);
        mark();
        for (int i = 0; i < 7; i++) begin
            flip();
            clean(1);
        end
        clean(50);
        for (int i = 0; i < 7; i++) begin
            flip();
            clean(1);
        end
        chk("win_no_loss", 64'(lp_seen), 64'(0));
        chk("win_err_cnt", 64'(err_cnt), 64'(14));
        chk("win_still_locked", 64'(locked), 64'(1));

        // 4: constant zero never locks
        do_reset();
        mark();
        repeat (100) step(1'b0, 1'b1);
        chk("t4_never_locked", 64'(ever_locked), 64'(0));
        chk("t4_err_cnt", 64'(err_cnt), 64'(0));

        // 5: 1-of-3 valid duty with random din on idle cycles
        do_reset();
        mark();
        for (int i = 0; i < 40; i++) begin
            step(next_pn(), 1'b1);
            step(1'($urandom), 1'b0);
            step(1'($urandom), 1'b0);
        end
        chk("t5_lock_valid_bits", 64'(lock_at), 64'(12));
        chk("t5_err_cnt", 64'(err_cnt), 64'(0));

        // 6: reset while locked with errors, then relock
        do_reset();
        clean(20);
        for (int i = 0; i < 5; i++) begin
            flip();
            clean(3);
        end
        chk("t6_err_cnt", 64'(err_cnt), 64'(5));
        chk("t6_locked", 64'(locked), 64'(1));
        do_reset();
        mark();
        clean(12);
        chk("t6_relock_bit", 64'(lock_at), 64'(12));
        chk("t6_err_cnt_cleared", 64'(err_cnt), 64'(0));

        // random errors and valid gaps, checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'($urandom), 1'b0);
            end else if ($urandom_range(0, 11) == 0) begin
                flip();
            end else begin
                clean(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
